// File: rtl/bp_io_reg_responder_if.sv
`default_nettype none
//== bp_io_reg_responder_if : uncached I/O command/response channel (I/O CCE <-> target) | rev 1.0 ==
interface bp_io_reg_responder_if #(
  parameter int MSG_WIDTH = 567
);
  logic [MSG_WIDTH-1:0] cmd;
  logic                 cmd_v;
  logic                 cmd_ready;
  logic [MSG_WIDTH-1:0] resp;
  logic                 resp_v;
  logic                 resp_yumi;

  modport master (
    output cmd, cmd_v, resp_yumi,
    input  cmd_ready, resp, resp_v
  );

  modport slave (
    input  cmd, cmd_v, resp_yumi,
    output cmd_ready, resp, resp_v
  );
endinterface
`default_nettype wire

// File: rtl/bp_io_reg_responder.sv
`default_nettype none
//== bp_io_reg_responder : uncached rd/wr target backed by a bank of 64-bit registers | rev 1.0 ==
//== Message layout (MSB..LSB): msg_type, addr, size, payload{lce_id, way_id, uncached}, data  ==
module bp_io_reg_responder #(
  parameter int                     PADDR_WIDTH  = 40,
  parameter int                     BLOCK_WIDTH  = 512,
  parameter int                     LCE_ID_WIDTH = 4,
  parameter int                     LCE_ASSOC    = 8,
  parameter int                     NUM_REGS     = 16,
  parameter logic [PADDR_WIDTH-1:0] BASE_ADDR    = PADDR_WIDTH'('h0020_0000)
) (
  input  wire logic              clk_i,
  input  wire logic              reset_n_i,
  bp_io_reg_responder_if.slave   io,
  output logic [7:0]             err_count_o
);

  localparam int c_way_w = $clog2(LCE_ASSOC);
  localparam int c_idx_w = $clog2(NUM_REGS);
  localparam int c_rep   = BLOCK_WIDTH / 64;

  localparam logic [3:0] c_uc_rd  = 4'd2;
  localparam logic [3:0] c_uc_wr  = 4'd3;
  localparam logic [2:0] c_size_1 = 3'd0;
  localparam logic [2:0] c_size_2 = 3'd1;
  localparam logic [2:0] c_size_4 = 3'd2;

  localparam logic [PADDR_WIDTH:0] c_base = {1'b0, BASE_ADDR};
  localparam logic [PADDR_WIDTH:0] c_end  = c_base + (PADDR_WIDTH+1)'(NUM_REGS * 8);

  typedef struct packed {
    logic [LCE_ID_WIDTH-1:0] lce_id;
    logic [c_way_w-1:0]      way_id;
    logic                    uncached;
  } payload_t;

  typedef struct packed {
    logic [3:0]             msg_type;
    logic [PADDR_WIDTH-1:0] addr;
    logic [2:0]             size;
    payload_t               payload;
  } header_t;

  typedef struct packed {
    header_t                header;
    logic [BLOCK_WIDTH-1:0] data;
  } msg_t;

  msg_t               w_cmd;
  msg_t               w_resp;
  logic               w_accept;
  logic               w_deq;
  logic               w_full;
  logic               w_empty;
  logic               w_hit;
  logic               w_aligned;
  logic               w_is_rd;
  logic               w_is_wr;
  logic               w_ok;
  logic               w_do_wr;
  logic               w_err;
  logic [c_idx_w-1:0] w_idx;
  logic [2:0]         w_off;
  logic [7:0]         w_be_base;
  logic [7:0]         w_be;
  logic [63:0]        w_wdata;
  logic [63:0]        w_rdata;
  logic               w_unused_data;

  logic [63:0]        r_regs [NUM_REGS];
  header_t            r_hdr  [2];
  logic [63:0]        r_dat  [2];
  logic               r_wptr;
  logic               r_rptr;
  logic [1:0]         r_count;
  logic               r_live;
  logic [7:0]         r_err_count;

  assign w_cmd         = io.cmd;
  assign w_unused_data = ^w_cmd.data[BLOCK_WIDTH-1:64];

  // Ready is held low through reset and comes up on the first edge after release.
  assign w_full       = (r_count == 2'd2);
  assign w_empty      = (r_count == 2'd0);
  assign io.cmd_ready = r_live & ~w_full;
  assign io.resp_v    = ~w_empty;
  assign w_accept     = io.cmd_v & io.cmd_ready;
  assign w_deq        = io.resp_yumi & ~w_empty;

  assign w_hit = ({1'b0, w_cmd.header.addr} >= c_base) & ({1'b0, w_cmd.header.addr} < c_end);
  assign w_idx = w_cmd.header.addr[3 +: c_idx_w];
  assign w_off = w_cmd.header.addr[2:0];

  always_comb begin
    w_be_base = 8'hFF;
    w_aligned = (w_off == 3'd0);
    case (w_cmd.header.size)
      c_size_1: begin
        w_be_base = 8'h01;
        w_aligned = 1'b1;
      end
      c_size_2: begin
        w_be_base = 8'h03;
        w_aligned = ~w_off[0];
      end
      c_size_4: begin
        w_be_base = 8'h0F;
        w_aligned = (w_off[1:0] == 2'd0);
      end
      default: begin
        w_be_base = 8'hFF;
        w_aligned = (w_off == 3'd0);
      end
    endcase
  end

  // Alignment guarantees off + bytes <= 8, so the shifted mask never wraps.
  assign w_be    = w_be_base << w_off;
  assign w_wdata = w_cmd.data[63:0] << {w_off, 3'b000};

  assign w_is_rd = (w_cmd.header.msg_type == c_uc_rd);
  assign w_is_wr = (w_cmd.header.msg_type == c_uc_wr);
  assign w_ok    = w_hit & w_aligned & (w_is_rd | w_is_wr);
  assign w_do_wr = w_accept & w_ok & w_is_wr;
  assign w_err   = w_accept & ~w_ok;
  assign w_rdata = (w_ok & w_is_rd) ? r_regs[w_idx] : 64'd0;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_regs[gi] <= '0;
        end else if (w_do_wr && (w_idx == c_idx_w'(gi))) begin
          for (int b = 0; b < 8; b++) begin
            if (w_be[b]) begin
              r_regs[gi][8*b +: 8] <= w_wdata[8*b +: 8];
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_live      <= 1'b0;
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_count     <= 2'd0;
      r_err_count <= 8'd0;
    end else begin
      r_live <= 1'b1;
      if (w_accept) begin
        r_wptr <= ~r_wptr;
      end
      if (w_deq) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_accept, w_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  // Only the 64-bit register value is stored; it is replicated across the block on output.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_hdr[r_wptr] <= w_cmd.header;
      r_dat[r_wptr] <= w_rdata;
    end
  end

  always_comb begin
    w_resp        = '0;
    w_resp.header = r_hdr[r_rptr];
    w_resp.data   = {c_rep{r_dat[r_rptr]}};
  end

  assign io.resp     = w_resp;
  assign err_count_o = r_err_count;

endmodule
`default_nettype wire
